// File: rtl/match_logger_pkg.sv
// rtl/match_logger_pkg.sv - shared widths and FIFO occupancy states for match_logger
package match_logger_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/match_fifo.sv
// rtl/match_fifo.sv - synchronous show-ahead FIFO holding tagged match events
module match_fifo
    import match_logger_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // A pop frees the head slot in the same edge, so a full FIFO may still accept a push.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/match_logger.sv
// rtl/match_logger.sv - timestamps rising edges of ans and queues them for readout
module match_logger
    import match_logger_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ans,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [CNT_W-1:0]         out_idx,
    output logic [CNT_W-1:0]         total,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int EW = TS_W + CNT_W;

    logic              ans_q;
    logic [TS_W-1:0]   ts;
    logic              rise;
    logic              push_req;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     head;
    fifo_state_e       fifo_state;

    assign rise      = ans & ~ans_q;
    assign push_req  = rise & ~clr;
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        fifo_state = FIFO_PARTIAL;
        if (fifo_empty) begin
            fifo_state = FIFO_EMPTY;
        end else if (fifo_full) begin
            fifo_state = FIFO_FULL;
        end
    end

    assign drop = push_req & (fifo_state == FIFO_FULL) & ~pop;

    // ans_q keeps tracking during clr so a level held across clr is not seen as a new rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans_q <= 1'b0;
        end else begin
            ans_q <= ans;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            total    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            ts       <= '0;
            total    <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (push_req && (total != '1)) begin
                total <= total + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    match_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push_req & ~drop),
        .pop   (pop),
        .din   ({ts, total}),
        .dout  (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_ts  = head[EW-1:CNT_W];
    assign out_idx = head[CNT_W-1:0];

endmodule

// File: tb/tb_match_logger.sv
// tb/tb_match_logger.sv - directed self-checking bench for match_logger
module tb_match_logger;

    logic        clk;
    logic        rst_n;
    logic        ans;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ts;
    logic [7:0]  out_idx;
    logic [7:0]  total;
    logic        overflow;
    logic [2:0]  level;

    logic        ans2;
    logic        clr2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] out_ts2;
    logic [1:0]  out_idx2;
    logic [1:0]  total2;
    logic        overflow2;
    logic [2:0]  level2;

    int checks   = 0;
    int failures = 0;

    match_logger #(.TS_W(16), .CNT_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ans       (ans),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_idx   (out_idx),
        .total     (total),
        .overflow  (overflow),
        .level     (level)
    );

    match_logger #(.TS_W(16), .CNT_W(2), .DEPTH(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .ans       (ans2),
        .clr       (clr2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_ts    (out_ts2),
        .out_idx   (out_idx2),
        .total     (total2),
        .overflow  (overflow2),
        .level     (level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_rise();
        ans = 1'b1;
        tick();
        ans = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ans = 1'b0; clr = 1'b0; out_ready = 1'b0;
        ans2 = 1'b0; clr2 = 1'b0; out_ready2 = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ts_out", 32'(out_ts), 32'd0);
        chk("rst_idx_out", 32'(out_idx), 32'd0);
        rst_n = 1'b1;

        // idle ten cycles
        for (int i = 0; i < 10; i++) tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_total", 32'(total), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);

        // single long pulse, rise while ts=5
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ans = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        ans = 1'b0;
        tick();
        chk("one_level", 32'(level), 32'd1);
        chk("one_total", 32'(total), 32'd1);
        chk("one_ts", 32'(out_ts), 32'd5);
        chk("one_idx", 32'(out_idx), 32'd0);
        chk("one_valid", 32'(out_valid), 32'd1);

        // five rises into a four-deep FIFO
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) pulse_rise();
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_total", 32'(total), 32'd5);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_hold_ts", 32'(out_ts), 32'd0);
        tick();
        chk("ovf_stable_idx", 32'(out_idx), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_idx%0d", i), 32'(out_idx), 32'(i));
            chk($sformatf("drain_ts%0d", i), 32'(out_ts), 32'(2 * i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // full FIFO, push and pop in the same edge
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) pulse_rise();
        chk("full_level", 32'(level), 32'd4);
        ans = 1'b1; out_ready = 1'b1;
        tick();
        ans = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_total", 32'(total), 32'd5);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("pp_idx%0d", i), 32'(out_idx), 32'(i));
            chk($sformatf("pp_ts%0d", i), 32'(out_ts), 32'(2 * i));
            tick();
        end
        out_ready = 1'b0;
        chk("pp_empty", 32'(out_valid), 32'd0);

        // clr coinciding with a rise at level 2
        clr = 1'b1; tick(); clr = 1'b0;
        pulse_rise();
        pulse_rise();
        chk("pre_clr_level", 32'(level), 32'd2);
        ans = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_total", 32'(total), 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        tick();
        chk("clr_held_no_rise", 32'(level), 32'd0);
        ans = 1'b0; tick();
        ans = 1'b1; tick();
        ans = 1'b0;
        chk("post_clr_idx", 32'(out_idx), 32'd0);
        chk("post_clr_ts", 32'(out_ts), 32'd2);
        chk("post_clr_level", 32'(level), 32'd1);

        // saturating two-bit counter with consumer always ready
        out_ready2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ans2 = 1'b1; tick();
            chk($sformatf("sat_valid%0d", i), 32'(out_valid2), 32'd1);
            chk($sformatf("sat_idx%0d", i), 32'(out_idx2), (i < 3) ? 32'(i) : 32'd3);
            ans2 = 1'b0; tick();
        end
        chk("sat_total", 32'(total2), 32'd3);
        chk("sat_level", 32'(level2), 32'd0);
        chk("sat_ovf", 32'(overflow2), 32'd0);

        // asynchronous reset mid-operation
        pulse_rise();
        pulse_rise();
        chk("pre_rst_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_total", 32'(total), 32'd0);
        chk("arst_ts_out", 32'(out_ts), 32'd0);
        chk("arst_total2", 32'(total2), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
